// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: opcodes, ALU operation encoding and decode bundles.
// The ALU encoding is shared with the EX stage.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    typedef enum logic [3:0] {
        ADD   = 4'd0,
        SUB   = 4'd1,
        AND   = 4'd2,
        OR    = 4'd3,
        SLT   = 4'd4,
        LUI   = 4'd5,
        RTYPE = 4'd15
    } alu_op_e;

    typedef enum logic [1:0] {
        IMM_SIGN = 2'd0,
        IMM_ZERO = 2'd1,
        IMM_LUI  = 2'd2
    } imm_kind_e;

    typedef struct packed {
        alu_op_e alu_op;
        logic    alu_src;
        logic    mem_write;
        logic    mem_read;
        logic    branch;
        logic    mem2reg;
        logic    reg_write;
        logic    illegal;
    } ex_ctrl_t;

    // Controls that travel to EX plus the ones consumed inside ID.
    typedef struct packed {
        ex_ctrl_t  ctrl;
        logic      reg_dst;
        logic      reads_rt;
        imm_kind_e imm_kind;
    } dec_t;

    localparam int DEC_W = $bits(dec_t);

endpackage

// File: rtl/id_decoder.sv
// Combinational opcode decoder: produces EX controls, destination select,
// rt-usage flag and immediate-extension kind as a flat dec_t vector.
module id_decoder
    import mips_pkg::*;
(
    input  logic [5:0]       opcode_i,
    output logic [DEC_W-1:0] dec_o
);

    dec_t dec;

    always_comb begin
        dec = '0;
        case (opcode_i)
            OP_RTYPE: begin
                dec.ctrl.alu_op    = RTYPE;
                dec.ctrl.reg_write = 1'b1;
                dec.reg_dst        = 1'b1;
                dec.reads_rt       = 1'b1;
            end
            OP_LW: begin
                dec.ctrl.alu_op    = ADD;
                dec.ctrl.alu_src   = 1'b1;
                dec.ctrl.mem_read  = 1'b1;
                dec.ctrl.mem2reg   = 1'b1;
                dec.ctrl.reg_write = 1'b1;
            end
            OP_SW: begin
                dec.ctrl.alu_op    = ADD;
                dec.ctrl.alu_src   = 1'b1;
                dec.ctrl.mem_write = 1'b1;
                dec.reads_rt       = 1'b1;
            end
            OP_BEQ: begin
                dec.ctrl.alu_op    = SUB;
                dec.ctrl.branch    = 1'b1;
                dec.reads_rt       = 1'b1;
            end
            OP_ADDI, OP_SLTI: begin
                dec.ctrl.alu_op    = (opcode_i == OP_ADDI) ? ADD : SLT;
                dec.ctrl.alu_src   = 1'b1;
                dec.ctrl.reg_write = 1'b1;
            end
            OP_ANDI, OP_ORI: begin
                dec.ctrl.alu_op    = (opcode_i == OP_ANDI) ? AND : OR;
                dec.ctrl.alu_src   = 1'b1;
                dec.ctrl.reg_write = 1'b1;
                dec.imm_kind       = IMM_ZERO;
            end
            OP_LUI: begin
                dec.ctrl.alu_op    = LUI;
                dec.ctrl.alu_src   = 1'b1;
                dec.ctrl.reg_write = 1'b1;
                dec.imm_kind       = IMM_LUI;
            end
            default: dec.ctrl.illegal = 1'b1;
        endcase
    end

    assign dec_o = dec;

endmodule

// File: rtl/id_stage_pipe.sv
// MIPS ID stage with ID/EX register, valid/ready flow control, load-use stall and flush.
// Optional macro ID_WB_BYPASS_EN forwards the write-back port into the captured operands.
module id_stage_pipe
    import mips_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            nrst,
    input  logic            i_IF_valid,
    input  logic [31:0]     i_IF_instr,
    input  logic [XLEN-1:0] i_IF_pcnext,
    output logic            o_IF_ready,
    output logic [4:0]      o_reg_addr1,
    output logic [4:0]      o_reg_addr2,
    input  logic [XLEN-1:0] i_reg_data1,
    input  logic [XLEN-1:0] i_reg_data2,
    input  logic            i_WB_we,
    input  logic [4:0]      i_WB_addr,
    input  logic [XLEN-1:0] i_WB_data,
    input  logic            i_flush,
    input  logic            i_EX_ready,
    output logic            o_EX_valid,
    output logic [XLEN-1:0] o_EX_data_RSData,
    output logic [XLEN-1:0] o_EX_data_RTData,
    output logic [4:0]      o_EX_data_RTAddr,
    output logic [4:0]      o_EX_data_DstAddr,
    output logic [XLEN-1:0] o_EX_data_ExtImm,
    output logic [4:0]      o_EX_data_Shamt,
    output logic [5:0]      o_EX_data_Funct,
    output logic [XLEN-1:0] o_EX_data_PCNext,
    output logic [3:0]      o_EX_ctrl_ALUOp,
    output logic            o_EX_ctrl_ALUSrc,
    output logic            o_EX_ctrl_MemWrite,
    output logic            o_EX_ctrl_MemRead,
    output logic            o_EX_ctrl_Branch,
    output logic            o_EX_ctrl_Mem2Reg,
    output logic            o_EX_ctrl_RegWrite,
    output logic            o_EX_illegal
);

    logic [4:0]       rs, rt, rd;
    logic [15:0]      imm;
    logic [DEC_W-1:0] dec_bits;
    dec_t             dec;
    logic [XLEN-1:0]  ext_imm, rs_data, rt_data;
    logic             hazard, adv;

    assign rs  = i_IF_instr[25:21];
    assign rt  = i_IF_instr[20:16];
    assign rd  = i_IF_instr[15:11];
    assign imm = i_IF_instr[15:0];
    assign o_reg_addr1 = rs;
    assign o_reg_addr2 = rt;

    id_decoder u_decoder (
        .opcode_i (i_IF_instr[31:26]),
        .dec_o    (dec_bits)
    );
    assign dec = dec_t'(dec_bits);

    always_comb begin
        ext_imm = {{(XLEN-16){imm[15]}}, imm};
        case (dec.imm_kind)
            IMM_ZERO: ext_imm = {{(XLEN-16){1'b0}}, imm};
            IMM_LUI: begin
                ext_imm       = '0;
                ext_imm[31:0] = {imm, 16'h0000};
            end
            default: ;
        endcase
    end

`ifdef ID_WB_BYPASS_EN
    // Register file may read the old value on a same-cycle write; take the WB data instead.
    assign rs_data = (i_WB_we && (i_WB_addr != 5'd0) && (i_WB_addr == rs)) ? i_WB_data : i_reg_data1;
    assign rt_data = (i_WB_we && (i_WB_addr != 5'd0) && (i_WB_addr == rt)) ? i_WB_data : i_reg_data2;
`else
    logic unused_wb;
    assign unused_wb = ^{i_WB_we, i_WB_addr, i_WB_data};
    assign rs_data   = i_reg_data1;
    assign rt_data   = i_reg_data2;
`endif

    logic            valid_q, valid_d;
    ex_ctrl_t        ctrl_q, ctrl_d;
    logic [XLEN-1:0] rs_data_q, rs_data_d, rt_data_q, rt_data_d;
    logic [XLEN-1:0] imm_q, imm_d, pcnext_q, pcnext_d;
    logic [4:0]      rt_addr_q, rt_addr_d, dst_q, dst_d, shamt_q, shamt_d;
    logic [5:0]      funct_q, funct_d;

    assign hazard = valid_q && ctrl_q.mem_read && (dst_q != 5'd0) &&
                    ((dst_q == rs) || ((dst_q == rt) && dec.reads_rt));
    assign adv        = ~valid_q | i_EX_ready;
    assign o_IF_ready = i_flush | (adv & ~hazard);

    // Flush beats stall beats load; a bubble only clears valid and controls.
    always_comb begin
        valid_d   = valid_q;
        ctrl_d    = ctrl_q;
        rs_data_d = rs_data_q;
        rt_data_d = rt_data_q;
        rt_addr_d = rt_addr_q;
        dst_d     = dst_q;
        imm_d     = imm_q;
        shamt_d   = shamt_q;
        funct_d   = funct_q;
        pcnext_d  = pcnext_q;
        if (adv && (i_flush || hazard || !i_IF_valid)) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
        end else if (adv && !i_flush) begin
            valid_d   = 1'b1;
            ctrl_d    = dec.ctrl;
            rs_data_d = rs_data;
            rt_data_d = rt_data;
            rt_addr_d = rt;
            dst_d     = dec.reg_dst ? rd : rt;
            imm_d     = ext_imm;
            shamt_d   = i_IF_instr[10:6];
            funct_d   = i_IF_instr[5:0];
            pcnext_d  = i_IF_pcnext;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            valid_q   <= 1'b0;
            ctrl_q    <= '0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            rt_addr_q <= '0;
            dst_q     <= '0;
            imm_q     <= '0;
            shamt_q   <= '0;
            funct_q   <= '0;
            pcnext_q  <= '0;
        end else begin
            valid_q   <= valid_d;
            ctrl_q    <= ctrl_d;
            rs_data_q <= rs_data_d;
            rt_data_q <= rt_data_d;
            rt_addr_q <= rt_addr_d;
            dst_q     <= dst_d;
            imm_q     <= imm_d;
            shamt_q   <= shamt_d;
            funct_q   <= funct_d;
            pcnext_q  <= pcnext_d;
        end
    end

    assign o_EX_valid         = valid_q;
    assign o_EX_data_RSData   = rs_data_q;
    assign o_EX_data_RTData   = rt_data_q;
    assign o_EX_data_RTAddr   = rt_addr_q;
    assign o_EX_data_DstAddr  = dst_q;
    assign o_EX_data_ExtImm   = imm_q;
    assign o_EX_data_Shamt    = shamt_q;
    assign o_EX_data_Funct    = funct_q;
    assign o_EX_data_PCNext   = pcnext_q;
    assign o_EX_ctrl_ALUOp    = ctrl_q.alu_op;
    assign o_EX_ctrl_ALUSrc   = ctrl_q.alu_src;
    assign o_EX_ctrl_MemWrite = ctrl_q.mem_write;
    assign o_EX_ctrl_MemRead  = ctrl_q.mem_read;
    assign o_EX_ctrl_Branch   = ctrl_q.branch;
    assign o_EX_ctrl_Mem2Reg  = ctrl_q.mem2reg;
    assign o_EX_ctrl_RegWrite = ctrl_q.reg_write;
    assign o_EX_illegal       = ctrl_q.illegal;

endmodule
